// File: rtl/datamem_arbiter.sv
// Round-robin arbiter sharing one single-port 256x8 data memory between the CPU
// (requester 0) and the DMA/debug loader (requester 1), with a bounded burst hold.
module datamem_arbiter #(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic [1:0]    owner
);

  localparam int unsigned CntW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StOwn0 = 2'b01,
    StOwn1 = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last_q, last_d;
  logic            pick0, pick1;
  logic            at_last;

  assign at_last = (cnt_q == CntLast);

  // Grant decision: an owner keeps the port until its burst budget runs out while the
  // other side waits; otherwise fall back to round-robin on last_q.
  always_comb begin
    pick0 = 1'b0;
    pick1 = 1'b0;
    if (state_q == StOwn0 && req0) begin
      if (req1 && at_last) pick1 = 1'b1;
      else                 pick0 = 1'b1;
    end else if (state_q == StOwn1 && req1) begin
      if (req0 && at_last) pick0 = 1'b1;
      else                 pick1 = 1'b1;
    end else if (req0 && req1) begin
      pick0 = last_q;
      pick1 = ~last_q;
    end else begin
      pick0 = req0;
      pick1 = req1;
    end
  end

  // Gating with rst_n keeps a write from landing while reset is asserted between edges.
  assign gnt0 = pick0 & rst_n;
  assign gnt1 = pick1 & rst_n;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (gnt0) begin
      state_d = StOwn0;
      last_d  = 1'b0;
      cnt_d   = (state_q == StOwn0 && !at_last) ? cnt_q + CntW'(1) : '0;
    end else if (gnt1) begin
      state_d = StOwn1;
      last_d  = 1'b1;
      cnt_d   = (state_q == StOwn1 && !at_last) ? cnt_q + CntW'(1) : '0;
    end else begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (gnt0) begin
      mem_we   = we0;
      mem_addr = addr0;
      mem_din  = wdata0;
    end else if (gnt1) begin
      mem_we   = we1;
      mem_addr = addr1;
      mem_din  = wdata1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if (gnt0 && !we0) rdata0 <= mem_dout;
      if (gnt1 && !we1) rdata1 <= mem_dout;
    end
  end

  assign owner = state_q;

endmodule

// File: doc/datamem_arbiter.md
Name: datamem_arbiter

Overview:
- Two-port arbiter that shares the single-port 256x8 data memory between requester 0 (CPU load/store stage) and requester 1 (DMA/debug loader).
- Grants one access per cycle and drives the memory's write enable, address and write-data inputs.
- Captures combinational read data into a per-requester registered response.
- Round-robin with a bounded burst hold, so a streaming requester cannot starve the other.

Parameters:
- AW, 8, address width (matches the 256-entry memory)
- DW, 8, data width
- MAX_BURST, 4, max consecutive grants to one requester while the other is waiting (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0 / req1  in  1  access request from requester 0 / 1, held until granted
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  AW  access address
- wdata0 / wdata1  in  DW  write data
- gnt0 / gnt1  out  1  access accepted this cycle (combinational)
- rdata0 / rdata1  out  DW  registered read data
- rvalid0 / rvalid1  out  1  one-cycle pulse, rdataN valid
- mem_we  out  1  to memory write enable
- mem_addr  out  AW  to memory address
- mem_din  out  DW  to memory write data
- mem_dout  in  DW  from memory, combinational read of mem_addr
- owner  out  2  00 idle, 01 req0 owns, 10 req1 owns (registered state)

Behaviour:
- State register: IDLE / OWN0 / OWN1, plus burst counter cnt (0..MAX_BURST-1) and last_gnt bit.
- Reset (async, rst_n low): state IDLE, cnt 0, last_gnt 1 (req0 wins the first tie), rdata0/1 0, rvalid0/1 0. gnt0/1 and mem_we forced 0 while rst_n is low.
- Grant decision, evaluated combinationally each cycle, at most one of gnt0/gnt1 high:
  - Owner k still requesting, and either cnt < MAX_BURST-1 or the other requester idle → grant k.
  - Owner k still requesting, cnt == MAX_BURST-1, other requesting → grant the other.
  - Otherwise (IDLE or owner dropped req): both requesting → grant ~last_gnt; one requesting → grant it; none → no grant.
- Memory drive: granted requester's we/addr/wdata go to mem_we/mem_addr/mem_din in the same cycle. With no grant: mem_we 0, mem_addr 0, mem_din 0.
- Writes commit at the rising edge ending the grant cycle.
- Read latency: read granted in cycle N → rdataN = mem_dout sampled at the end of N, rvalidN high for cycle N+1 only. Write grants produce no rvalid.
- rdataN holds its value until the next read grant to N.
- Next-state update on each rising edge:
  - Grant to k: state OWNk, last_gnt = k. cnt = cnt+1 if k was already owner and cnt < MAX_BURST-1, else 0.
  - Owner k keeps the grant at cnt == MAX_BURST-1 because the other is idle: cnt wraps to 0.
  - No grant: state IDLE, cnt 0, last_gnt unchanged.
- MAX_BURST = 1 gives strict alternation whenever both requesters are active.
- Requester must hold req/we/addr/wdata stable until gnt. The arbiter never latches a request, so a request dropped before gnt is simply lost with no side effect.
- Same-cycle read-after-write to one address cannot occur (single port). A read granted the cycle after a write returns the new data.
- Reset asserted mid-burst: state, counter and response flags clear immediately. Any write whose edge did not occur is not performed. A pending rvalid is dropped.
- No combinational path from mem_dout to any output except through the rdata registers.

Test Plan:
- Reset: hold rst_n low with req0=req1=1 → gnt0=gnt1=0, mem_we=0, rvalid0/1=0, owner=00. Release → first grant goes to req0.
- Single write then read by req0: write addr 0x10 data 0xA5, then read 0x10 → gnt0 each cycle, mem_we=1 only on the write, rvalid0 pulses one cycle after the read grant with rdata0=0xA5.
- Contention with MAX_BURST=4, both requesting continuously, req0 reads 0x00..0x07, req1 reads 0x80..0x87 → grant pattern 4×req0, 4×req1, 4×req0…. rvalid never high on both ports in the same cycle.
- Burst wrap with req1 idle: req0 issues 10 consecutive reads → gnt0 every cycle, no bubble at the cnt wrap, owner stays 01.
- Tie after IDLE: req1 granted last, then one idle cycle, then both request → req0 granted (last_gnt rule). Repeat with req0 last → req1 granted.
- Mid-burst async reset: assert rst_n low between edges during a req1 write to 0x20 (old value 0x11, new 0x22) → no commit, memory still 0x11, rvalid1=0. After release, arbitration restarts with owner=00.
